instr_encoder: RTL
==================

Name: instr_encoder

Overview:
- Program-loader block: accepts one MIPS instruction per handshake as mnemonic code plus fields, packs it into a 32-bit word, and writes it sequentially into instruction memory.
- Inverse of the control decoder. Emits exactly the opcode/funct set that the pipeline decodes: add, sub, and, or, slt, addi, andi, lw, sw, j, beq, bne.
- Sits between the testbench/boot source and the instruction-memory write port.

Parameters:
- ADDR_W, 6: word-address width; capacity DEPTH = 2**ADDR_W words.
- BASE_ADDR, 0: first word address written after start.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  asynchronous, active-low reset.
- start  input  1  one-cycle pulse; begins a new program load at BASE_ADDR.
- in_valid  input  1  instruction fields valid.
- in_ready  output  1  encoder can accept fields this cycle.
- in_last  input  1  current instruction is the last of the program.
- mnem  input  4  0 add, 1 sub, 2 and, 3 or, 4 slt, 5 addi, 6 andi, 7 lw, 8 sw, 9 j, 10 beq, 11 bne.
- rs, rt, rd  input  5 each  register fields.
- imm  input  16  immediate / branch offset.
- target  input  26  jump target field.
- mem_we  output  1  instruction-memory write strobe.
- mem_addr  output  ADDR_W  write address.
- mem_wdata  output  32  encoded word.
- count  output  ADDR_W+1  words written since start.
- done  output  1  program load complete (level).
- err  output  1  load aborted (level).

Behaviour:
- States: IDLE, RUN, DONE, ERR. Reset (rst=0, async) forces IDLE; all outputs 0; mem_addr = BASE_ADDR.
- IDLE: in_ready=0. start -> RUN; clear count, done, err; address := BASE_ADDR.
- RUN: in_ready=1 unless a write is pending that would make the load full.
- Accept: in_valid && in_ready in cycle N. Encoded word is registered; mem_we=1 in cycle N+1 with current mem_addr. Address and count increment at the end of N+1. Back-to-back accepts sustain 1 word/cycle.
- Encoding:
  - R-type: {6'b000000, rs, rt, rd, 5'b0, funct}; funct add 100000, sub 100010, and 100100, or 100101, slt 101010.
  - I-type: {op, rs, rt, imm}; op addi 001000, andi 001100, lw 100011, sw 101011, beq 000100, bne 000101.
  - j: {000010, target}.
- mnem 12..15 on accept: no write; next state ERR; err=1.
- in_last accepted: the word is written in N+1, then DONE with done=1. in_ready=0 in DONE and ERR.
- Full: writing address BASE_ADDR+DEPTH-1 without in_last -> DONE with err=1 (overflow). Address never wraps.
- start while in RUN: restart. The pending write in flight still completes; the address then resets to BASE_ADDR.
- start in DONE/ERR: new load.
- Simultaneous start and accept in RUN: start wins; the fields are dropped.
- in_valid in IDLE is ignored.

Optional Feature:
- Macro INSTR_ENCODER_DELAY_NOP_EN.
- Defined: after each j/beq/bne word, the encoder writes 32'h00000000 at the next address in the following cycle. in_ready=0 during that cycle; count includes the NOP. If the branch was in_last, the NOP is written before entering DONE. If there is no room for the NOP, the overflow rule applies.
- Undefined: no padding.

Test Plan:
- Reset low mid-RUN -> all outputs 0, state IDLE immediately (async), no further mem_we.
- start, add rs=1 rt=2 rd=3 -> mem_we next cycle, addr 0, wdata 0x00221820.
- Stream addi rs=0 rt=1 imm=5; lw rs=0 rt=5 imm=8; beq rs=1 rt=2 imm=0xFFFF (last) -> addrs 0,1,2; wdata 0x20010005, 0x8C050008, 0x1022FFFF; done=1; count=3.
- j target=0x10 with DELAY_NOP_EN -> 0x08000010 at addr 0, 0x00000000 at addr 1, in_ready=0 for one cycle; count=2.
- mnem=13 -> no write, err=1, in_ready=0; a later start clears err.
- ADDR_W=2, stream 5 words without in_last -> 4 writes (addr 0..3), then done=1, err=1, fifth word never accepted.

Source files
------------

// File: rtl/instr_encoder.sv
`default_nettype none
// ============================================================================
// instr_encoder : packs MIPS instruction fields into 32-bit words and writes
//                 them sequentially into instruction memory.
// Optional macro INSTR_ENCODER_DELAY_NOP_EN : pad j/beq/bne with a NOP word.
// Revision      : 1.0
// ============================================================================
module instr_encoder #(
    parameter int ADDR_W    = 6,
    parameter int BASE_ADDR = 0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic              in_last,
    input  logic [3:0]        mnem,
    input  logic [4:0]        rs,
    input  logic [4:0]        rt,
    input  logic [4:0]        rd,
    input  logic [15:0]       imm,
    input  logic [25:0]       target,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    output logic [ADDR_W:0]   count,
    output logic              done,
    output logic              err
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2,
        ERR  = 2'd3
    } state_t;

    localparam logic [ADDR_W-1:0] C_BASE_ADDR = ADDR_W'(BASE_ADDR);
    // The load stops at the top of memory so the address never wraps.
    localparam logic [ADDR_W-1:0] C_LAST_ADDR = {ADDR_W{1'b1}};

    state_t            r_state, w_state_nx;
    logic [ADDR_W-1:0] r_addr, w_addr_nx;
    logic [ADDR_W:0]   r_count, w_count_nx;
    logic              r_we, w_we_nx;
    logic [31:0]       r_wdata, w_wdata_nx;
    logic              r_last, w_last_nx;
    logic              r_done, w_done_nx;
    logic              r_err, w_err_nx;
    logic [31:0]       w_word;
    logic              w_legal;
    logic              w_nop_pend;

`ifdef INSTR_ENCODER_DELAY_NOP_EN
    logic r_nop, w_nop_nx;
    logic w_branch;
    assign w_branch   = (mnem == 4'd9) || (mnem == 4'd10) || (mnem == 4'd11);
    assign w_nop_pend = r_nop;
`else
    assign w_nop_pend = 1'b0;
`endif

    always_comb begin
        w_word  = '0;
        w_legal = 1'b1;
        case (mnem)
            4'd0:    w_word = {6'b000000, rs, rt, rd, 5'b00000, 6'b100000};
            4'd1:    w_word = {6'b000000, rs, rt, rd, 5'b00000, 6'b100010};
            4'd2:    w_word = {6'b000000, rs, rt, rd, 5'b00000, 6'b100100};
            4'd3:    w_word = {6'b000000, rs, rt, rd, 5'b00000, 6'b100101};
            4'd4:    w_word = {6'b000000, rs, rt, rd, 5'b00000, 6'b101010};
            4'd5:    w_word = {6'b001000, rs, rt, imm};
            4'd6:    w_word = {6'b001100, rs, rt, imm};
            4'd7:    w_word = {6'b100011, rs, rt, imm};
            4'd8:    w_word = {6'b101011, rs, rt, imm};
            4'd9:    w_word = {6'b000010, target};
            4'd10:   w_word = {6'b000100, rs, rt, imm};
            4'd11:   w_word = {6'b000101, rs, rt, imm};
            default: w_legal = 1'b0;
        endcase
    end

    always_comb begin
        w_state_nx = r_state;
        w_addr_nx  = r_addr;
        w_count_nx = r_count;
        w_we_nx    = 1'b0;
        w_wdata_nx = r_wdata;
        w_last_nx  = r_last;
        w_done_nx  = r_done;
        w_err_nx   = r_err;
`ifdef INSTR_ENCODER_DELAY_NOP_EN
        w_nop_nx   = 1'b0;
`endif
        // A write that ends the load or needs a NOP slot blocks new fields.
        in_ready = (r_state == RUN) &&
                   !(r_we && (r_last || (r_addr == C_LAST_ADDR) || w_nop_pend));

        if (r_we) begin
            w_count_nx = r_count + 1'b1;
            if (r_addr != C_LAST_ADDR)
                w_addr_nx = r_addr + 1'b1;
            if (w_nop_pend && (r_addr != C_LAST_ADDR)) begin
                w_we_nx    = 1'b1;
                w_wdata_nx = '0;
            end else if (r_last || (r_addr == C_LAST_ADDR)) begin
                w_state_nx = DONE;
                w_done_nx  = 1'b1;
                w_err_nx   = !r_last || w_nop_pend;
            end
        end

        if (in_valid && in_ready) begin
            if (w_legal) begin
                w_we_nx    = 1'b1;
                w_wdata_nx = w_word;
                w_last_nx  = in_last;
`ifdef INSTR_ENCODER_DELAY_NOP_EN
                w_nop_nx   = w_branch;
`endif
            end else begin
                w_state_nx = ERR;
                w_err_nx   = 1'b1;
            end
        end

        // Start overrides everything; an in-flight write still drives the port.
        if (start) begin
            w_state_nx = RUN;
            w_addr_nx  = C_BASE_ADDR;
            w_count_nx = '0;
            w_we_nx    = 1'b0;
            w_last_nx  = 1'b0;
            w_done_nx  = 1'b0;
            w_err_nx   = 1'b0;
`ifdef INSTR_ENCODER_DELAY_NOP_EN
            w_nop_nx   = 1'b0;
`endif
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= IDLE;
            r_addr  <= C_BASE_ADDR;
            r_count <= '0;
            r_we    <= 1'b0;
            r_wdata <= '0;
            r_last  <= 1'b0;
            r_done  <= 1'b0;
            r_err   <= 1'b0;
`ifdef INSTR_ENCODER_DELAY_NOP_EN
            r_nop   <= 1'b0;
`endif
        end else begin
            r_state <= w_state_nx;
            r_addr  <= w_addr_nx;
            r_count <= w_count_nx;
            r_we    <= w_we_nx;
            r_wdata <= w_wdata_nx;
            r_last  <= w_last_nx;
            r_done  <= w_done_nx;
            r_err   <= w_err_nx;
`ifdef INSTR_ENCODER_DELAY_NOP_EN
            r_nop   <= w_nop_nx;
`endif
        end
    end

    assign mem_we    = r_we;
    assign mem_addr  = r_addr;
    assign mem_wdata = r_wdata;
    assign count     = r_count;
    assign done      = r_done;
    assign err       = r_err;

endmodule
`default_nettype wire
